// File: rtl/tiny_rv_pkg.sv
// Shared types for the tiny RV front end: fetch FSM states, slot payload, PC helper.
package tiny_rv_pkg;

  localparam int unsigned RV_ILEN = 32;
  localparam int unsigned RV_XLEN = 32;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_ILEN-1:0] instr;
  } fetch_slot_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [RV_XLEN-1:0] pc_inc(input logic [RV_XLEN-1:0] pc);
    return pc + RV_XLEN'(4);
  endfunction

endpackage

// File: rtl/tiny_rv_fetch_seq_if.sv
// Fetch sequencer bus bundle: imem request/response, decode slot, branch redirect, trap.
interface tiny_rv_fetch_seq_if;
  import tiny_rv_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [RV_XLEN-1:0] imem_req_addr;
  logic               imem_rsp_valid;
  logic [RV_ILEN-1:0] imem_rsp_data;
  logic               id_valid;
  logic               id_ready;
  logic [RV_XLEN-1:0] id_pc;
  logic [RV_XLEN-1:0] id_next_pc;
  logic [RV_ILEN-1:0] id_instr;
  logic               br_valid;
  logic               br_taken;
  logic [RV_XLEN-1:0] br_addr;
  logic               trap;
  logic [RV_XLEN-1:0] trap_tval;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_next_pc, id_instr,
           trap, trap_tval,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           br_valid, br_taken, br_addr
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_next_pc, id_instr,
           trap, trap_tval,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           br_valid, br_taken, br_addr
  );

endinterface

// File: rtl/tiny_rv_fetch_slot.sv
// Single-entry valid/ready instruction slot toward decode, with a same-cycle kill.
module tiny_rv_fetch_slot
  import tiny_rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  fetch_slot_t i_wdata,
  input  logic        i_kill,
  input  logic        i_ready,
  output logic        o_valid_c,
  output logic        o_fire_c,
  output logic        o_free_c,
  output fetch_slot_t o_data
);

  logic        r_valid;
  fetch_slot_t r_data;

  // A killed slot is hidden from decode in the same cycle it is cleared.
  assign o_valid_c = r_valid & ~i_kill;
  assign o_fire_c  = o_valid_c & i_ready;
  assign o_free_c  = ~r_valid | o_fire_c;
  assign o_data    = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_kill) begin
        r_valid <= 1'b0;
      end else if (i_wr) begin
        r_valid <= 1'b1;
      end else if (o_fire_c) begin
        r_valid <= 1'b0;
      end
      if (i_wr) begin
        r_data <= i_wdata;
      end
    end
  end

endmodule

// File: rtl/tiny_rv_fetch_seq.sv
// PC sequencer / fetch controller: single-outstanding imem fetch, one decode slot,
// taken-branch redirect with in-flight kill and misaligned-target trap.
module tiny_rv_fetch_seq
  import tiny_rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  tiny_rv_fetch_seq_if.master fetch_if
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [RV_XLEN-1:0] r_fetch_pc;
  logic [RV_XLEN-1:0] w_fetch_pc_nxt;
  fetch_slot_t        r_pend;
  logic               r_trap;
  logic [RV_XLEN-1:0] r_trap_tval;

  logic               w_redirect;
  logic               w_misalign;
  logic [RV_XLEN-1:0] w_target;
  logic               w_req_valid_c;
  logic               w_slot_wr;
  fetch_slot_t        w_slot_wdata;
  logic               w_pend_ld;
  logic               w_slot_valid_c;
  logic               w_slot_fire_c;
  logic               w_slot_free_c;
  fetch_slot_t        w_slot_data;

  assign w_redirect = fetch_if.br_valid & fetch_if.br_taken;
  assign w_misalign = |fetch_if.br_addr[1:0];
  assign w_target   = w_misalign ? TRAP_VEC : fetch_if.br_addr;

  tiny_rv_fetch_slot u_slot (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr      (w_slot_wr),
    .i_wdata   (w_slot_wdata),
    .i_kill    (w_redirect),
    .i_ready   (fetch_if.id_ready),
    .o_valid_c (w_slot_valid_c),
    .o_fire_c  (w_slot_fire_c),
    .o_free_c  (w_slot_free_c),
    .o_data    (w_slot_data)
  );

  // Next-state, PC and slot-write decisions; redirect overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_valid_c  = 1'b0;
    w_slot_wr      = 1'b0;
    w_slot_wdata   = '{pc: r_fetch_pc, instr: fetch_if.imem_rsp_data};
    w_pend_ld      = 1'b0;

    unique case (r_state)
      REQ: begin
        w_req_valid_c = 1'b1;
        if (fetch_if.imem_req_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (fetch_if.imem_rsp_valid) begin
          w_fetch_pc_nxt = pc_inc(r_fetch_pc);
          if (w_slot_free_c) begin
            w_slot_wr   = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_pend_ld   = 1'b1;
            w_state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (w_slot_fire_c) begin
          w_slot_wr    = 1'b1;
          w_slot_wdata = r_pend;
          w_state_nxt  = REQ;
        end
      end
      DRAIN: begin
        if (fetch_if.imem_rsp_valid) begin
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = REQ;
      end
    endcase

    if (w_redirect) begin
      w_fetch_pc_nxt = w_target;
      w_slot_wr      = 1'b0;
      w_pend_ld      = 1'b0;
      unique case (r_state)
        REQ:     w_state_nxt = fetch_if.imem_req_ready ? DRAIN : REQ;
        WAIT:    w_state_nxt = fetch_if.imem_rsp_valid ? REQ : DRAIN;
        FULL:    w_state_nxt = REQ;
        DRAIN:   w_state_nxt = fetch_if.imem_rsp_valid ? REQ : DRAIN;
        default: w_state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= REQ;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  // Response that arrived while the slot was occupied; handed over once decode drains it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
    end else if (w_pend_ld) begin
      r_pend <= w_slot_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trap      <= 1'b0;
      r_trap_tval <= '0;
    end else begin
      r_trap <= w_redirect & w_misalign;
      if (w_redirect & w_misalign) begin
        r_trap_tval <= fetch_if.br_addr;
      end
    end
  end

  // Request valid is gated by reset so it is low while reset is held.
  assign fetch_if.imem_req_valid = w_req_valid_c & i_rst_n;
  assign fetch_if.imem_req_addr  = r_fetch_pc;
  assign fetch_if.id_valid       = w_slot_valid_c;
  assign fetch_if.id_pc          = w_slot_data.pc;
  assign fetch_if.id_next_pc     = pc_inc(w_slot_data.pc);
  assign fetch_if.id_instr       = w_slot_data.instr;
  assign fetch_if.trap           = r_trap;
  assign fetch_if.trap_tval      = r_trap_tval;

endmodule
